// File: rtl/vram_arb_pkg.sv
// Shared types and helpers for the VRAM write-port arbiter.
// Helpers operate on a MAX_REQ-wide vector; callers size-cast to their own requester count.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } arb_state_t;

    localparam int PIXELS  = 640 * 480;
    localparam int MAX_REQ = 32;

    function automatic logic [MAX_REQ-1:0] onehot(input int idx);
        return MAX_REQ'(1) << idx;
    endfunction

    function automatic int oh_index(input logic [MAX_REQ-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational rotating one-hot picker: the first set request at or after i_start wins.
// Rotate down, isolate the lowest set bit, rotate back up.
module arb_priority_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_grant
);

    logic [2*N-1:0] w_dbl_req;
    logic [N-1:0]   w_rot_req;
    logic [N-1:0]   w_rot_gnt;
    logic [2*N-1:0] w_dbl_gnt;

    assign w_dbl_req = {i_req, i_req} >> i_start;
    assign w_rot_req = w_dbl_req[N-1:0];
    assign w_rot_gnt = w_rot_req & ~(w_rot_req - N'(1));
    assign w_dbl_gnt = {w_rot_gnt, w_rot_gnt} << i_start;
    assign o_grant   = w_dbl_gnt[2*N-1:N];

endmodule

// File: rtl/vram_write_arbiter.sv
// Shares the single VRAM write port among NUM_REQ requesters with optional locked bursts.
// Define VRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module vram_write_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1,
    parameter int NUM_REQ        = 3,
    parameter int MAX_BURST      = 1024
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_lock_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [ADDR_WIDTH-1:0]         vram_write_address_o,
    output logic [DATA_WIDTH-1:0]         vram_write_data_o,
    output logic                          wr_vram_ena_o,
    output logic                          drop_o,
    output logic                          busy_o
);

    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = $clog2(MAX_BURST + 1);
    localparam int CELLS = ACTIVE_COLUMNS * ACTIVE_ROWS;
    localparam logic [ADDR_WIDTH:0] CELLS_W = (ADDR_WIDTH + 1)'(CELLS);

    arb_state_t              r_state;
    logic [NUM_REQ-1:0]      r_grant;
    logic [CW-1:0]           r_cnt;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic                    r_wr_ena;
    logic                    r_drop;

    logic [ADDR_WIDTH-1:0]   w_addr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_data [NUM_REQ];
    logic [IW-1:0]           w_gidx;
    logic [IW-1:0]           w_start;
    logic                    w_beat;
    logic                    w_g_valid;
    logic                    w_g_lock;
    logic [NUM_REQ-1:0]      w_others;
    logic [NUM_REQ-1:0]      w_pick_all;
    logic [NUM_REQ-1:0]      w_pick_ex;
    logic [NUM_REQ-1:0]      w_pick;
    logic                    w_arb;
    logic                    w_win_lock;
    logic                    w_in_range;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi] = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_data[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_gidx     = IW'(oh_index(MAX_REQ'(r_grant)));
    assign w_g_valid  = |(req_valid_i & r_grant);
    assign w_g_lock   = |(req_lock_i & r_grant);
    assign w_beat     = w_g_valid;
    assign w_others   = req_valid_i & ~NUM_REQ'(onehot(int'(w_gidx)));
    assign w_in_range = {1'b0, w_addr[w_gidx]} < CELLS_W;

`ifdef VRAM_ARB_RR_EN
    logic [IW-1:0] r_rr_ptr;
    assign w_start = r_rr_ptr;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_ptr <= '0;
        end else if (w_arb && |w_pick) begin
            r_rr_ptr <= IW'((oh_index(MAX_REQ'(w_pick)) + 1) % NUM_REQ);
        end
    end
`else
    assign w_start = '0;
`endif

    arb_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick_all (
        .i_req   (req_valid_i),
        .i_start (w_start),
        .o_grant (w_pick_all)
    );

    arb_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick_ex (
        .i_req   (w_others),
        .i_start (w_start),
        .o_grant (w_pick_ex)
    );

    // Forced release prefers anyone but the current owner; the owner only keeps the port when alone.
    always_comb begin
        w_arb  = 1'b0;
        w_pick = w_pick_all;
        case (r_state)
            IDLE:  w_arb = 1'b1;
            GRANT: w_arb = w_beat || !w_g_valid;
            BURST: begin
                if (w_beat && r_cnt == CW'(MAX_BURST - 1)) begin
                    w_arb  = 1'b1;
                    w_pick = (|w_pick_ex) ? w_pick_ex : w_pick_all;
                end else if (!w_g_lock) begin
                    w_arb = w_beat || !w_g_valid;
                end
            end
            default: w_arb = 1'b1;
        endcase
    end

    assign w_win_lock = |(req_lock_i & w_pick);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_ena  <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_wr_ena <= w_beat && w_in_range;
            r_drop   <= w_beat && !w_in_range;
            if (w_beat && w_in_range) begin
                r_wr_addr <= w_addr[w_gidx];
                r_wr_data <= w_data[w_gidx];
            end

            if (w_arb) begin
                r_grant <= w_pick;
                r_cnt   <= '0;
                if (|w_pick) r_state <= w_win_lock ? BURST : GRANT;
                else         r_state <= IDLE;
            end else if (r_state == BURST) begin
                if (w_beat)    r_cnt   <= r_cnt + CW'(1);
                if (!w_g_lock) r_state <= GRANT;
            end
        end
    end

    assign req_ready_o          = r_grant;
    assign grant_o              = r_grant;
    assign vram_write_address_o = r_wr_addr;
    assign vram_write_data_o    = r_wr_data;
    assign wr_vram_ena_o        = r_wr_ena;
    assign drop_o               = r_drop;
    assign busy_o               = (r_state != IDLE);

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed self-checking bench for vram_write_arbiter (MAX_BURST=4); expectations track VRAM_ARB_RR_EN.
module tb_vram_write_arbiter;

    localparam int NR = 3;
    localparam int AW = 19;
    localparam int DW = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_lock = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     grant;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_ena;
    logic              drop;
    logic              busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vram_write_arbiter #(.MAX_BURST(4)) dut (
        .clk_i                (clk),
        .reset_i              (reset),
        .req_valid_i          (req_valid),
        .req_lock_i           (req_lock),
        .req_addr_i           (req_addr),
        .req_data_i           (req_data),
        .req_ready_o          (req_ready),
        .grant_o              (grant),
        .vram_write_address_o (wr_addr),
        .vram_write_data_o    (wr_data),
        .wr_vram_ena_o        (wr_ena),
        .drop_o               (drop),
        .busy_o               (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_lock[i]          = l;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_lock  = '0;
        reset     = 1'b1;
        step();
        step();
        reset     = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic e, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check({tag, "_ena"}, 32'(wr_ena), 32'(e));
        if (e) begin
            check({tag, "_addr"}, 32'(wr_addr), 32'(a));
            check({tag, "_data"}, 32'(wr_data), 32'(d));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle: every output quiet for 10 cycles.
        do_reset();
        check("rst_grant", 32'(grant), 32'h0);
        for (int c = 0; c < 10; c++) begin
            step();
            check("idle_outputs", {grant, req_ready, wr_ena, drop, busy, 2'b0, wr_addr, wr_data}, 32'h0);
        end

        // Single beat from req1.
        set_req(1, 1'b1, 1'b0, 19'd5, 1'b1);
        step();
        check("single_grant", 32'(grant), 32'h2);
        check("single_ready", 32'(req_ready), 32'h2);
        check("single_busy", 32'(busy), 32'h1);
        check_write("single_pre", 1'b0, '0, '0);
        step();
        check_write("single_wr", 1'b1, 19'd5, 1'b1);
        check("single_drop", 32'(drop), 32'h0);
        set_req(1, 1'b0, 1'b0, 19'd5, 1'b1);
        step();
        check("single_idle", {grant, wr_ena, busy}, 32'h0);
        step();
        check("single_idle2", {grant, wr_ena, busy}, 32'h0);

        // Req0 and req2 continuously valid.
        do_reset();
        set_req(0, 1'b1, 1'b0, 19'd10, 1'b1);
        set_req(2, 1'b1, 1'b0, 19'd20, 1'b0);
        step();
        check("contend_first", 32'(grant), 32'h1);
        for (int k = 0; k < 6; k++) begin
            step();
`ifdef VRAM_ARB_RR_EN
            check("contend_grant", 32'(grant), (k % 2 == 0) ? 32'h4 : 32'h1);
            if (k % 2 == 0) check_write("contend_wr", 1'b1, 19'd10, 1'b1);
            else            check_write("contend_wr", 1'b1, 19'd20, 1'b0);
`else
            check("contend_grant", 32'(grant), 32'h1);
            check_write("contend_wr", 1'b1, 19'd10, 1'b1);
`endif
        end
        req_valid = '0;
        step();
        step();
        check("contend_idle", {grant, wr_ena, busy}, 32'h0);

        // Locked burst with forced release after 4 beats.
        do_reset();
        set_req(0, 1'b1, 1'b1, 19'd100, 1'b1);
        set_req(1, 1'b1, 1'b0, 19'd200, 1'b0);
        step();
        check("burst_grant", 32'(grant), 32'h1);
        check("burst_busy", 32'(busy), 32'h1);
        for (int b = 0; b < 3; b++) begin
            step();
            check("burst_hold", 32'(grant), 32'h1);
            check_write("burst_wr", 1'b1, 19'd100, 1'b1);
        end
        step();
        check("burst_release", 32'(grant), 32'h2);
        check_write("burst_wr4", 1'b1, 19'd100, 1'b1);
        step();
        check("burst_regrant", 32'(grant), 32'h1);
        check_write("burst_req1_wr", 1'b1, 19'd200, 1'b0);
        set_req(1, 1'b0, 1'b0, 19'd200, 1'b0);
        for (int b = 0; b < 2; b++) begin
            step();
            check("burst_tail", 32'(grant), 32'h1);
            check_write("burst_tail_wr", 1'b1, 19'd100, 1'b1);
        end
        set_req(0, 1'b0, 1'b0, 19'd100, 1'b1);
        step();
        check("burst_idle", {grant, wr_ena, busy}, 32'h0);

        // Out-of-range address is accepted but dropped.
        do_reset();
        set_req(2, 1'b1, 1'b0, 19'd307200, 1'b1);
        step();
        check("oor_grant", 32'(grant), 32'h4);
        step();
        check("oor_ena", 32'(wr_ena), 32'h0);
        check("oor_drop", 32'(drop), 32'h1);
        check("oor_addr_hold", 32'(wr_addr), 32'h0);
        set_req(2, 1'b0, 1'b0, 19'd307200, 1'b1);
        step();
        check("oor_drop_end", 32'(drop), 32'h0);
        check("oor_idle", {grant, wr_ena, busy}, 32'h0);

        // Reset asserted during the third beat of a locked burst.
        do_reset();
        set_req(0, 1'b1, 1'b1, 19'd50, 1'b1);
        step();
        check("rstb_grant", 32'(grant), 32'h1);
        step();
        check_write("rstb_wr1", 1'b1, 19'd50, 1'b1);
        step();
        check_write("rstb_wr2", 1'b1, 19'd50, 1'b1);
        set_req(0, 1'b1, 1'b1, 19'd51, 1'b1);
        reset = 1'b1;
        step();
        check("rstb_state", {grant, wr_ena, busy, drop}, 32'h0);
        check("rstb_addr", 32'(wr_addr), 32'h0);
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 19'd51, 1'b1);
        step();
        check("rstb_after", {grant, wr_ena, busy}, 32'h0);
        check("rstb_addr2", 32'(wr_addr), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
